// File: rtl/jtcps1_pal_dma_if.sv
// Signal bundle between the palette copy engine, the CPU side, the VRAM read
// slot and the palette RAM write port.
interface jtcps1_pal_dma_if;
  logic        pal_copy;
  logic [15:0] pal_base;
  logic [5:0]  pal_page_en;
  logic        VB;
  logic        vram_cs;
  logic [16:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_ok;
  logic        pal_we;
  logic [11:0] pal_wr_addr;
  logic [15:0] pal_wr_data;
  logic        busy;
  logic        done;

  modport master (
    input  pal_copy, pal_base, pal_page_en, VB, vram_data, vram_ok,
    output vram_cs, vram_addr, pal_we, pal_wr_addr, pal_wr_data, busy, done
  );

  modport slave (
    output pal_copy, pal_base, pal_page_en, VB, vram_data, vram_ok,
    input  vram_cs, vram_addr, pal_we, pal_wr_addr, pal_wr_data, busy, done
  );
endinterface

// File: rtl/jtcps1_pal_dma.sv
// Palette copy engine: after a palette-base write, waits for vertical blank and
// copies the enabled 512-word pages from VRAM into the 4096x16 palette RAM.
module jtcps1_pal_dma (
  input  logic              clk,
  input  logic              rst,
  jtcps1_pal_dma_if.master  bus
);
  typedef enum logic [2:0] {IDLE, WAIT_VB, PAGE, REQ, WR, FIN} state_t;

  state_t      state_q, state_d;
  logic [16:0] src_q, src_d;
  logic [11:0] dst_q, dst_d;
  logic [5:0]  mask_q, mask_d;
  logic [9:0]  pbase_q, pbase_d;
  logic [5:0]  pmask_q, pmask_d;
  logic        pend_q, pend_d;
  logic        first_q;
  logic        cs_q, cs_d;
  logic [16:0] vaddr_q, vaddr_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  mask_ext;
  logic        unused_base;

  assign mask_ext    = {2'b00, mask_q};
  assign unused_base = ^bus.pal_base[15:10];

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    mask_d  = mask_q;
    pbase_d = pbase_q;
    pmask_d = pmask_q;
    pend_d  = pend_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    // Requests arriving while busy collapse into one shadowed retrigger
    if (bus.pal_copy && state_q != IDLE) begin
      pend_d  = 1'b1;
      pbase_d = bus.pal_base[9:0];
      pmask_d = bus.pal_page_en;
    end

    case (state_q)
      IDLE: if (bus.pal_copy) begin
        src_d   = {bus.pal_base[9:0], 7'd0};
        mask_d  = bus.pal_page_en;
        state_d = WAIT_VB;
      end
      WAIT_VB: if (bus.VB) begin
        dst_d   = '0;
        state_d = PAGE;
      end
      PAGE: begin
        if (mask_ext[dst_q[11:9]]) begin
          state_d = REQ;
        end else begin
          dst_d = dst_q + 12'h200;
          if (dst_d == 12'hC00) state_d = FIN;
        end
      end
      REQ: if (!first_q && bus.vram_ok) begin
        // Counters advance at capture so WR can steer on the incremented dst
        wdata_d = bus.vram_data;
        waddr_d = dst_q;
        dst_d   = dst_q + 12'd1;
        src_d   = src_q + 17'd1;
        state_d = WR;
      end
      WR: begin
        if (dst_q == 12'hC00)      state_d = FIN;
        else if (dst_q[8:0] == '0) state_d = PAGE;
        else                       state_d = REQ;
      end
      FIN: begin
        if (pend_q || bus.pal_copy) begin
          src_d   = {(bus.pal_copy ? bus.pal_base[9:0] : pbase_q), 7'd0};
          mask_d  = bus.pal_copy ? bus.pal_page_en : pmask_q;
          pend_d  = 1'b0;
          state_d = WAIT_VB;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cs_d    = (state_d == REQ);
    vaddr_d = (state_d == REQ) ? src_d : vaddr_q;
    we_d    = (state_d == WR);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      mask_q  <= '0;
      pbase_q <= '0;
      pmask_q <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b1;
      cs_q    <= 1'b0;
      vaddr_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      mask_q  <= mask_d;
      pbase_q <= pbase_d;
      pmask_q <= pmask_d;
      pend_q  <= pend_d;
      first_q <= (state_q != REQ);
      cs_q    <= cs_d;
      vaddr_q <= vaddr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.vram_cs     = cs_q;
  assign bus.vram_addr   = vaddr_q;
  assign bus.pal_we      = we_q;
  assign bus.pal_wr_addr = waddr_q;
  assign bus.pal_wr_data = wdata_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_jtcps1_pal_dma.sv
// Bench for jtcps1_pal_dma: VRAM responder with random ack latency, write
// monitor, and a page-list reference model of the expected palette contents.
module tb_jtcps1_pal_dma;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtcps1_pal_dma_if bus();
  jtcps1_pal_dma dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [15:0] seed;
  bit          stale_mode;
  bit          fixed_lat;

  logic [27:0] wq[$];
  logic [27:0] eq[$];
  int          reads, dones, b2b_err, overlap_err, addr_err;
  bit          prev_we, prev_cs, first_rd_seen;
  logic [16:0] first_rd_addr;

  function automatic logic [15:0] vval(input logic [16:0] a);
    return a[15:0] ^ seed;
  endfunction

  // VRAM read slot: ack after a per-request latency, optional stale first-cycle ack
  int          rcnt, rlat;
  logic [16:0] req_addr;
  always begin
    @(posedge clk); #1;
    if (rst || !bus.vram_cs) begin
      bus.vram_ok = 1'b0;
      rcnt = 0;
    end else begin
      if (rcnt == 0) begin
        req_addr = bus.vram_addr;
        rlat = stale_mode ? 3 : (fixed_lat ? 1 : int'($urandom_range(1, 3)));
      end else if (bus.vram_addr !== req_addr) begin
        addr_err = addr_err + 1;
      end
      if (stale_mode && rcnt == 0) begin
        bus.vram_ok   = 1'b1;
        bus.vram_data = ~vval(bus.vram_addr);
      end else if (rcnt == rlat) begin
        bus.vram_ok   = 1'b1;
        bus.vram_data = vval(bus.vram_addr);
      end else begin
        bus.vram_ok   = 1'b0;
        bus.vram_data = 16'($urandom);
      end
      rcnt = rcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pal_we) wq.push_back({bus.pal_wr_addr, bus.pal_wr_data});
      if (bus.pal_we && prev_we) b2b_err <= b2b_err + 1;
      if (bus.pal_we && bus.vram_cs) overlap_err <= overlap_err + 1;
      if (bus.vram_cs && !prev_cs) begin
        reads <= reads + 1;
        if (!first_rd_seen) begin
          first_rd_addr <= bus.vram_addr;
          first_rd_seen <= 1'b1;
        end
      end
      if (bus.done) dones <= dones + 1;
    end
    prev_we <= bus.pal_we;
    prev_cs <= bus.vram_cs;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete(); eq.delete();
    reads = 0; dones = 0; b2b_err = 0; overlap_err = 0; addr_err = 0;
    first_rd_seen = 1'b0;
  endtask

  // Expected writes: each enabled page p takes the next 512 consecutive source words
  task automatic build(input logic [15:0] base, input logic [5:0] mask);
    logic [16:0] src;
    src = {base[9:0], 7'd0};
    for (int p = 0; p < 6; p++) begin
      if (mask[p]) begin
        for (int w = 0; w < 512; w++) begin
          eq.push_back({12'(p * 512 + w), vval(src)});
          src = src + 17'd1;
        end
      end
    end
  endtask

  task automatic pulse_copy(input logic [15:0] base, input logic [5:0] mask);
    bus.pal_base = base;
    bus.pal_page_en = mask;
    bus.pal_copy = 1'b1;
    tick();
    bus.pal_copy = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!bus.done && cyc < max);
    chk({tag, "_done_seen"}, bus.done, 1);
  endtask

  task automatic wait_writes(input string tag, input int n);
    int c = 0;
    while (wq.size() < n && c < 5000) begin
      tick();
      c++;
    end
    chk({tag, "_reached"}, (wq.size() >= n), 1);
  endtask

  task automatic cmp_writes(input string tag);
    int nbad = 0;
    chk({tag, "_count"}, wq.size(), eq.size());
    for (int i = 0; i < wq.size() && i < eq.size(); i++)
      if (wq[i] !== eq[i]) nbad++;
    chk({tag, "_data"}, nbad, 0);
    chk({tag, "_we_b2b"}, b2b_err, 0);
    chk({tag, "_cs_we_overlap"}, overlap_err, 0);
    chk({tag, "_addr_stable"}, addr_err, 0);
  endtask

  function automatic longint outs();
    return {bus.vram_cs, bus.vram_addr, bus.pal_we, bus.pal_wr_addr,
            bus.pal_wr_data, bus.busy, bus.done};
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c2, cs_seen;
    logic [15:0] b;
    bus.pal_copy = 1'b0; bus.pal_base = '0; bus.pal_page_en = '0; bus.VB = 1'b0;
    bus.vram_data = '0; bus.vram_ok = 1'b0;
    stale_mode = 1'b0; fixed_lat = 1'b1; seed = '0;
    rst = 1'b1;
    clear_mon();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", outs(), 0);

    // All pages, VRAM[i]=i, fixed latency for the cycle-count check
    clear_mon();
    build(16'h0900, 6'h3F);
    pulse_copy(16'h0900, 6'h3F);
    chk("t1_busy_rise", bus.busy, 1);
    cs_seen = 0;
    repeat (5) begin tick(); cs_seen += bus.vram_cs; end
    chk("t1_no_cs_before_vb", cs_seen, 0);
    bus.VB = 1'b1;
    c = 0;
    do begin tick(); c++; end while (!bus.vram_cs && c < 20);
    chk("t1_cs_latency", c, 2);
    bus.VB = 1'b0;
    wait_done("t1", 12000, c2);
    chk("t1_total_cycles", c + c2, 9223);
    tick();
    chk("t1_busy_fall", bus.busy, 0);
    repeat (3) tick();
    chk("t1_done_pulses", dones, 1);
    chk("t1_reads", reads, 3072);
    cmp_writes("t1");

    // Page skip with random latency
    seed = 16'($urandom); fixed_lat = 1'b0; bus.VB = 1'b1;
    b = 16'($urandom);
    clear_mon();
    build(b, 6'b100101);
    pulse_copy(b, 6'b100101);
    wait_done("t2", 20000, c);
    repeat (3) tick();
    chk("t2_reads", reads, 1536);
    cmp_writes("t2");

    // Stale ack in first REQ cycle, real ack three cycles later
    seed = 16'($urandom); stale_mode = 1'b1;
    b = 16'($urandom);
    clear_mon();
    build(b, 6'b000001);
    pulse_copy(b, 6'b000001);
    wait_done("t3", 5000, c);
    repeat (3) tick();
    cmp_writes("t3");
    stale_mode = 1'b0;

    // Wait for blank, then collapsing retrigger mid-copy
    seed = 16'($urandom); fixed_lat = 1'b1; bus.VB = 1'b0;
    b = 16'($urandom);
    clear_mon();
    build(b, 6'h3F);
    build(16'h0A00, 6'h3F);
    pulse_copy(b, 6'h3F);
    cs_seen = 0;
    repeat (10) begin tick(); cs_seen += bus.vram_cs; end
    chk("t4_no_cs_before_vb", cs_seen, 0);
    bus.VB = 1'b1;
    wait_writes("t4", 50);
    pulse_copy(16'($urandom), 6'($urandom));
    pulse_copy(16'h0A00, 6'h3F);
    wait_done("t4_first", 12000, c);
    chk("t4_busy_at_first_done", bus.busy, 1);
    tick();
    chk("t4_busy_held", bus.busy, 1);
    wait_done("t4_second", 12000, c);
    tick();
    chk("t4_busy_fall", bus.busy, 0);
    repeat (3) tick();
    chk("t4_done_pulses", dones, 2);
    cmp_writes("t4");

    // Source address wrap
    seed = 16'($urandom); fixed_lat = 1'b0;
    clear_mon();
    build(16'h03FF, 6'h01);
    pulse_copy(16'h03FF, 6'h01);
    wait_done("t5", 5000, c);
    repeat (3) tick();
    chk("t5_first_addr", first_rd_addr, 17'h1FF80);
    cmp_writes("t5");

    // Reset mid-copy, then restart
    seed = 16'($urandom);
    clear_mon();
    pulse_copy(16'($urandom), 6'h3F);
    wait_writes("t6", 100);
    rst = 1'b1;
    #1;
    chk("t6_reset_outputs", outs(), 0);
    c = wq.size();
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();
    chk("t6_no_writes_after_reset", wq.size(), c);
    chk("t6_idle_after_reset", bus.busy, 0);
    b = 16'($urandom);
    clear_mon();
    build(b, 6'h01);
    pulse_copy(b, 6'h01);
    wait_done("t6", 5000, c);
    repeat (3) tick();
    chk("t6_first_dst", (wq.size() > 0) ? longint'(wq[0][27:16]) : -1, 0);
    cmp_writes("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
